// File: rtl/seq_alu_pkg.sv
// Purpose : shared opcode constants and FSM state type for the sequential ALU/accumulator.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package seq_alu_pkg;

  // Function opcodes
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SEXT = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_HOLD = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Purpose : shift-add multiplier core, one multiplier bit consumed per step.
// Latency : WIDTH steps after load; prod_nxt is the final product during the step where last=1.
// Backpr. : none; the owner drives step every cycle while the multiply is in flight.
// Ports   : clk, rst_n (async active-low); load latches a/b and clears product/counter;
//           step advances one bit; last flags the final step; prod_nxt = product after this step.
module seq_alu_mul
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] prod_nxt
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand;   // multiplicand, shifted left once per step
  logic [WIDTH-1:0]   mplier;  // multiplier, shifted right so bit 0 is always the current bit
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;

  assign prod_nxt = prod + (mplier[0] ? mcand : '0);
  assign last     = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= '0;
    end else if (step) begin
      prod   <= prod_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu_acc.sv
// Purpose : registered ALU/accumulator; operand B is fed back from the low WIDTH bits of ALUout.
// Latency : single-cycle ops write ALUout at the accepting edge (done next cycle); multiply takes WIDTH edges.
// Backpr. : start is only sampled in IDLE; while busy it is ignored, never queued.
// Ports   : Clock, Reset_b (async active-low), start/Data/Function request, busy, done pulse,
//           ALUout accumulator; flags[1:0] = {carry/borrow, zero} when SEQ_ALU_FLAGS_EN is defined.
module seq_alu_acc
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               Clock,
  input  logic               Reset_b,
  input  logic               start,
  input  logic [WIDTH-1:0]   Data,
  input  logic [2:0]         Function,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] ALUout
`ifdef SEQ_ALU_FLAGS_EN
  ,
  output logic [1:0]         flags
`endif
);

  state_e             state, state_nxt;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] a_ext, b_ext, add_sum, op_res, alu_nxt, mul_prod_nxt;
  logic               alu_wr, done_nxt, mul_load, mul_step, mul_last;

  assign b     = ALUout[WIDTH-1:0];
  assign a_ext = {{WIDTH{1'b0}}, Data};
  assign b_ext = {{WIDTH{1'b0}}, b};
  assign add_sum = a_ext + b_ext;
  assign busy  = (state == MUL);

  // Single-cycle datapath
  always_comb begin
    op_res = ALUout;
    case (Function)
      OP_ADD:  op_res = add_sum;
      OP_SUB:  op_res = a_ext - b_ext;
      OP_SEXT: op_res = {{WIDTH{b[WIDTH-1]}}, b};
      OP_OR:   op_res = {{(2*WIDTH-1){1'b0}}, |{Data, b}};
      OP_AND:  op_res = {{(2*WIDTH-1){1'b0}}, &{Data, b}};
      // Shifting by the full result width or more clears everything.
      OP_SHL:  op_res = (32'(Data) >= 2*WIDTH) ? '0 : (b_ext << Data);
      default: op_res = ALUout;
    endcase
  end

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk      (Clock),
    .rst_n    (Reset_b),
    .load     (mul_load),
    .step     (mul_step),
    .a        (Data),
    .b        (b),
    .last     (mul_last),
    .prod_nxt (mul_prod_nxt)
  );

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state  <= IDLE;
      done   <= 1'b0;
      ALUout <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (alu_wr) ALUout <= alu_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    alu_nxt   = op_res;
    alu_wr    = 1'b0;
    done_nxt  = 1'b0;
    mul_load  = 1'b0;
    mul_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (Function == OP_MUL) begin
            mul_load  = 1'b1;
            state_nxt = MUL;
          end else begin
            // Hold still completes a request, so it pulses done without writing.
            done_nxt = 1'b1;
            alu_wr   = (Function != OP_HOLD);
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          alu_nxt   = mul_prod_nxt;
          alu_wr    = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic op_cy, flag_cy;

  always_comb begin
    op_cy = 1'b0;
    case (Function)
      OP_ADD:  op_cy = add_sum[WIDTH];
      OP_SUB:  op_cy = (Data < b);
      default: op_cy = 1'b0;
    endcase
  end

  // A completed multiply never reports carry.
  assign flag_cy = (state == IDLE) ? op_cy : 1'b0;

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b)    flags <= 2'b00;
    else if (alu_wr) flags <= {flag_cy, (alu_nxt == '0)};
  end
`endif

endmodule

// File: tb/tb_seq_alu_acc.sv
module tb_seq_alu_acc;
  import seq_alu_pkg::*;

  localparam int WIDTH = 4;

  logic               Clock;
  logic               Reset_b;
  logic               start;
  logic [WIDTH-1:0]   Data;
  logic [2:0]         Function;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] ALUout;
`ifdef SEQ_ALU_FLAGS_EN
  logic [1:0]         flags;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  seq_alu_acc #(.WIDTH(WIDTH)) dut (
    .Clock    (Clock),
    .Reset_b  (Reset_b),
    .start    (start),
    .Data     (Data),
    .Function (Function),
    .busy     (busy),
    .done     (done),
    .ALUout   (ALUout)
`ifdef SEQ_ALU_FLAGS_EN
    ,
    .flags    (flags)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; presents one request for one rising edge and
  // returns at the next falling edge with the result settled.
  task automatic issue(input logic [WIDTH-1:0] d, input logic [2:0] f);
    start    = 1'b1;
    Data     = d;
    Function = f;
    @(negedge Clock);
    start    = 1'b0;
  endtask

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] d;
    logic [2:0]       f;
    logic [7:0]       exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int busy_cnt, done_cnt, done_idx, overlap;

    Reset_b  = 1'b0;
    start    = 1'b0;
    Data     = '0;
    Function = OP_ADD;

    // Reset state
    repeat (2) @(negedge Clock);
    check("rst_alu", 32'(ALUout), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
`ifdef SEQ_ALU_FLAGS_EN
    check("rst_flags", 32'(flags), 32'h0);
`endif
    Reset_b = 1'b1;
    @(negedge Clock);

    // Back-to-back adds; done stays high across them
    issue(4'd5, OP_ADD);
    check("add5_alu", 32'(ALUout), 32'h05);
    check("add5_done", 32'(done), 32'h1);
    issue(4'd3, OP_ADD);
    check("add3_alu", 32'(ALUout), 32'h08);
    check("add3_done", 32'(done), 32'h1);
    @(negedge Clock);
    check("idle_done", 32'(done), 32'h0);
    check("idle_alu", 32'(ALUout), 32'h08);

    // Multiply 7 * 8 with a stray start while busy
    issue(4'd7, OP_MUL);
    busy_cnt = 0; done_cnt = 0; done_idx = -1; overlap = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) begin
        busy_cnt++;
        check("mul_alu_held", 32'(ALUout), 32'h08);
      end
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (busy && done) overlap++;
      if (i == 1) begin
        start = 1'b1; Data = 4'd1; Function = OP_ADD;
      end else begin
        start = 1'b0;
      end
      @(negedge Clock);
    end
    check("mul_busy_cycles", 32'(busy_cnt), 32'd4);
    check("mul_done_pulses", 32'(done_cnt), 32'd1);
    check("mul_done_pos", 32'(done_idx), 32'd4);
    check("mul_overlap", 32'(overlap), 32'd0);
    check("mul_result", 32'(ALUout), 32'h38);
`ifdef SEQ_ALU_FLAGS_EN
    check("mul_flags", 32'(flags), 32'h0);
`endif

    // Reset in the middle of a multiply
    issue(4'd3, OP_MUL);
    check("mul2_busy", 32'(busy), 32'h1);
    @(negedge Clock);
    #2 Reset_b = 1'b0;
    #1;
    check("abort_alu", 32'(ALUout), 32'h00);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    @(negedge Clock);
    Reset_b = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (done || busy) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    issue(4'd2, OP_ADD);
    check("post_abort_add", 32'(ALUout), 32'h02);

    // Directed single-cycle vectors; each expectation follows from the previous ALUout
    vecs.push_back('{"shl_a8",    4'd8,  OP_SHL,  8'h00}); // B=2, A==2W -> 0
    vecs.push_back('{"add_2",     4'd2,  OP_ADD,  8'h02}); // 2+0
    vecs.push_back('{"shl_a9",    4'd9,  OP_SHL,  8'h00}); // A>2W -> 0
    vecs.push_back('{"add_2b",    4'd2,  OP_ADD,  8'h02});
    vecs.push_back('{"shl_2",     4'd2,  OP_SHL,  8'h08}); // 2<<2
    vecs.push_back('{"sub_zero",  4'd8,  OP_SUB,  8'h00}); // 8-8
    vecs.push_back('{"or_zero",   4'd0,  OP_OR,   8'h00}); // {0,0}
    vecs.push_back('{"or_one",    4'd4,  OP_OR,   8'h01}); // A=4
    vecs.push_back('{"and_part",  4'd15, OP_AND,  8'h00}); // B=1
    vecs.push_back('{"add_15",    4'd15, OP_ADD,  8'h0F}); // 15+0
    vecs.push_back('{"and_all",   4'd15, OP_AND,  8'h01}); // {F,F}
    vecs.push_back('{"add_9",     4'd9,  OP_ADD,  8'h0A}); // 9+1
    vecs.push_back('{"sext_neg",  4'd0,  OP_SEXT, 8'hFA}); // B=A
    vecs.push_back('{"sub_wrap",  4'd3,  OP_SUB,  8'hF9}); // 3-10 mod 256
    vecs.push_back('{"hold",      4'd5,  OP_HOLD, 8'hF9});
    vecs.push_back('{"sub_6",     4'd15, OP_SUB,  8'h06}); // 15-9
    vecs.push_back('{"add_8",     4'd2,  OP_ADD,  8'h08}); // 2+6
    foreach (vecs[i]) begin
      issue(vecs[i].d, vecs[i].f);
      check(vecs[i].tag, 32'(ALUout), 32'(vecs[i].exp));
      check({vecs[i].tag, "_done"}, 32'(done), 32'h1);
    end

    // Carry, hold and zero; flags tracked when present
    issue(4'd9, OP_ADD);
    check("add_carry", 32'(ALUout), 32'h11);
`ifdef SEQ_ALU_FLAGS_EN
    check("add_carry_flags", 32'(flags), 32'h2);
`endif
    issue(4'd0, OP_HOLD);
    check("hold2_alu", 32'(ALUout), 32'h11);
    check("hold2_done", 32'(done), 32'h1);
`ifdef SEQ_ALU_FLAGS_EN
    check("hold2_flags", 32'(flags), 32'h2);
`endif
    issue(4'd1, OP_SUB);
    check("sub_to_zero", 32'(ALUout), 32'h00);
`ifdef SEQ_ALU_FLAGS_EN
    check("sub_zero_flags", 32'(flags), 32'h1);
`endif
    issue(4'd3, OP_ADD);
    issue(4'd1, OP_SUB);
    check("sub_borrow", 32'(ALUout), 32'hFE);
`ifdef SEQ_ALU_FLAGS_EN
    check("sub_borrow_flags", 32'(flags), 32'h2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_alu_acc.md
Name: seq_alu_acc

Overview:
- Parametrised successor to the 4-bit registered ALU/accumulator.
- Operand A comes from the Data input. Operand B is the low WIDTH bits of the accumulator (ALUout), giving a feedback loop.
- All results are registered. Multiplication is multi-cycle (shift-add, one bit per clock) instead of combinational.
- A start/busy/done handshake lets a controller or FSM sequence operations.

Parameters:
- WIDTH, 4, operand width in bits (>=2); result/accumulator width is 2*WIDTH.

Ports:
- Clock  in  1  system clock, rising-edge.
- Reset_b  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled on a rising edge only in IDLE.
- Data  in  WIDTH  operand A.
- Function  in  3  opcode, sampled with start.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse when a result (or hold) has completed.
- ALUout  out  2*WIDTH  accumulator/result register.

Behaviour:
- Reset (Reset_b=0, asynchronous): ALUout=0, busy=0, done=0, state=IDLE, multiplier internals=0. Release is synchronous to the next edge.
- B = ALUout[WIDTH-1:0] at the accepting edge. For a multiply, A and B are latched at that edge.
- Opcodes (results are 2*WIDTH, zero-extended unless stated):
  - 000: A+B (carry lands in bit WIDTH).
  - 001: A-B computed modulo 2^(2*WIDTH).
  - 010: B sign-extended to 2*WIDTH.
  - 011: 1 if any bit of {A,B} is set, else 0.
  - 100: 1 if all bits of {A,B} are set, else 0.
  - 101: B<<A; result=0 when A>=2*WIDTH.
  - 110: A*B, multi-cycle.
  - 111: hold, ALUout unchanged.
- FSM states: IDLE, MUL.
- IDLE, start=0: ALUout holds; done=0.
- IDLE, start=1, single-cycle opcode (all except 110):
  - ALUout is written at the accepting edge.
  - done=1 for the following cycle only.
  - Stay in IDLE. Back-to-back starts are allowed every cycle; done stays high while they continue.
- IDLE, start=1, Function=110:
  - Latch multiplicand/multiplier, clear partial product and counter.
  - busy=1; go to MUL. ALUout is not yet changed.
- MUL, each edge:
  - If the current multiplier bit is 1, add the shifted multiplicand to the partial product.
  - Increment the counter.
  - On the edge where counter==WIDTH-1: ALUout=product, busy=0, done=1 next cycle, go to IDLE.
  - Total latency: WIDTH edges after the accepting edge.
- start asserted in MUL is ignored; it is neither queued nor a protocol error.
- Data/Function may change freely after acceptance; the multiply uses latched values.
- Reset asserted in MUL aborts: all outputs clear immediately; no done pulse.
- busy and done are never high in the same cycle.

Optional Feature:
- Macro: SEQ_ALU_FLAGS_EN.
- When defined: adds output port flags[1:0], registered with ALUout.
  - flags[0] = zero (ALUout==0 after the write).
  - flags[1] = carry/borrow: bit WIDTH of the add for 000; borrow (A<B) for 001; 0 for all other ops.
  - Updated only when ALUout is written; held on 111 and during MUL; cleared by reset.
- When not defined: no flags port and no flag logic. All other behaviour is identical.

Decomposition:
- Package seq_alu_pkg:
  - Opcode constants: OP_ADD, OP_SUB, OP_SEXT, OP_OR, OP_AND, OP_SHL, OP_MUL, OP_HOLD.
  - FSM state type (IDLE, MUL).
- Sub-module seq_alu_mul: shift-add multiplier core with load, step, and last signals, counter, and partial-product register.
- The top level owns opcode decode, single-cycle datapath, FSM, and the ALUout register.

Test Plan (WIDTH=4):
- Reset then add: hold Reset_b=0 → ALUout=0x00, busy=0, done=0. Release; start, Data=5, Function=000 → ALUout=0x05 after the edge; done pulses 1 cycle. Then Data=3, 000 → ALUout=0x08.
- Multiply: ALUout=0x08, start, Data=7, Function=110 → busy=1 for 4 cycles; ALUout stays 0x08 until the 4th edge, then becomes 0x38; done pulses once, after busy falls.
- Start ignored while busy: in MUL, pulse start with Data=1, Function=000 → no effect; final ALUout=0x38 and exactly one done pulse.
- Reset mid-multiply: assert Reset_b=0 at cycle 2 of MUL → ALUout=0, busy=0 immediately; no done pulse; next add Data=2 → 0x02.
- Shift, reduce, sign-extend: B=0x2, Data=9, 101 → 0x00 (A>=8); B=0x2, Data=2, 101 → 0x08; ALUout=0, Data=0, 011 → 0x00; ALUout=0x0A, Data=0, 010 → 0xFA.
- Hold and flags (SEQ_ALU_FLAGS_EN): ALUout=0x08 (B=8), Data=9, 000 → ALUout=0x11, flags=2'b10. Then 111 → ALUout=0x11 and flags unchanged; done pulses. Then B=0x1, Data=1, 001 → ALUout=0x00, flags=2'b01.
